// File: rtl/chip_stock_arbiter.sv
// rtl/chip_stock_arbiter.sv - per-colour chip stock counters with sorter/dispenser update arbitration
module chip_stock_arbiter #(
    parameter int WIDTH        = 6,
    parameter int CAP          = 63,
    parameter int PULSE_CYCLES = 50000,
    parameter int GAP_CYCLES   = 25000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sort_req,
    input  logic [1:0]       sort_color,
    output logic             sort_ack,
    output logic             sort_full,
    input  logic             disp_req,
    input  logic [1:0]       disp_color,
    input  logic [WIDTH-1:0] disp_count,
    output logic             disp_busy,
    output logic             disp_done,
    output logic             disp_err,
    output logic [2:0]       eject,
    output logic [WIDTH-1:0] red_count,
    output logic [WIDTH-1:0] green_count,
    output logic [WIDTH-1:0] blue_count
);

    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0]    PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]    GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [WIDTH-1:0] CAP_V      = WIDTH'(CAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_GRANT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_stock [3];
    logic [1:0]        r_col;
    logic [WIDTH-1:0]  r_rem;
    logic [TW-1:0]     r_timer;
    logic              r_last_disp;

    logic [WIDTH-1:0]  w_sort_cnt;
    logic [WIDTH-1:0]  w_disp_cnt;
    logic              w_sort_valid;
    logic              w_sort_elig;
    logic              w_disp_elig;
    logic              w_sort_gnt;
    logic              w_disp_gnt;
    logic              w_check_bad;

    assign red_count   = r_stock[0];
    assign green_count = r_stock[1];
    assign blue_count  = r_stock[2];

    always_comb begin
        w_sort_cnt = '0;
        w_disp_cnt = '0;
        case (sort_color)
            2'd0:    w_sort_cnt = r_stock[0];
            2'd1:    w_sort_cnt = r_stock[1];
            2'd2:    w_sort_cnt = r_stock[2];
            default: w_sort_cnt = '0;
        endcase
        case (r_col)
            2'd0:    w_disp_cnt = r_stock[0];
            2'd1:    w_disp_cnt = r_stock[1];
            2'd2:    w_disp_cnt = r_stock[2];
            default: w_disp_cnt = '0;
        endcase
    end

    assign w_sort_valid = (sort_color != 2'd3);
    assign sort_full    = w_sort_valid && (w_sort_cnt == CAP_V);
    assign w_sort_elig  = sort_req && w_sort_valid && (w_sort_cnt < CAP_V);
    assign w_disp_elig  = (r_state == S_WAIT_GRANT);

    // On a tie the side that did not win last time gets the update path.
    assign w_sort_gnt = w_sort_elig && (!w_disp_elig || r_last_disp);
    assign w_disp_gnt = w_disp_elig && (!w_sort_elig || !r_last_disp);
    assign sort_ack   = w_sort_gnt;

    assign w_check_bad = (r_col == 2'd3) || (r_rem == '0) || (r_rem > w_disp_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        disp_busy = (r_state != S_IDLE);
        disp_done = 1'b0;
        disp_err  = 1'b0;
        eject     = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (disp_req) w_next = S_CHECK;
            end
            S_CHECK: begin
                disp_err = w_check_bad;
                w_next   = w_check_bad ? S_IDLE : S_WAIT_GRANT;
            end
            S_WAIT_GRANT: begin
                if (w_disp_gnt) w_next = S_PULSE;
            end
            S_PULSE: begin
                eject = 3'b001 << r_col;
                if (r_timer == '0) w_next = S_GAP;
            end
            S_GAP: begin
                if (r_timer == '0) w_next = (r_rem != '0) ? S_WAIT_GRANT : S_DONE;
            end
            S_DONE: begin
                disp_done = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) r_stock[c] <= '0;
            r_col       <= 2'd0;
            r_rem       <= '0;
            r_timer     <= '0;
            r_last_disp <= 1'b1;
        end else begin
            if (r_state == S_IDLE && disp_req) begin
                r_col <= disp_color;
                r_rem <= disp_count;
            end
            // The timer is loaded on the grant so PULSE lasts exactly PULSE_CYCLES.
            if (w_disp_gnt) begin
                r_rem   <= r_rem - 1'b1;
                r_timer <= PULSE_LOAD;
            end else if (r_state == S_PULSE && r_timer == '0) begin
                r_timer <= GAP_LOAD;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - 1'b1;
            end
            if (w_sort_gnt || w_disp_gnt) r_last_disp <= w_disp_gnt;
            for (int c = 0; c < 3; c++) begin
                if (w_sort_gnt && sort_color == 2'(c)) begin
                    r_stock[c] <= r_stock[c] + 1'b1;
                end else if (w_disp_gnt && r_col == 2'(c)) begin
                    r_stock[c] <= r_stock[c] - 1'b1;
                end
            end
        end
    end

endmodule
